alu_issue_queue: RTL and testbench



---
 rtl/alu_defs_pkg.sv | 30 +++
 rtl/cmd_fifo.sv | 59 +++++
 rtl/alu_issue_queue.sv | 118 +++++++++++
 tb/tb_alu_issue_queue.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs_pkg.sv
// alu_defs: definitions shared by the 16-bit ALU, its issue queue and benches.
//   - 4-bit ALU opcode encodings
//   - issue-queue FSM state encoding
//   - helper that classifies an opcode as one the ALU should execute
package alu_defs;

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_MULT  = 4'b0011;
  localparam logic [3:0] OP_DIV   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1000;
  localparam logic [3:0] OP_RESET = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // ADD..NOT form a contiguous range; NOOP, RESET and 1001-1110 never go
  // to the ALU. Divide-by-zero is filtered separately since it needs operand b.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_NOT);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous FIFO with registered occupancy.
//   clk, rst_n        clock, async active-low reset (pointers and count only)
//   push, push_data   write at tail; ignored when full
//   pop, pop_data     pop_data always shows the head; pop ignored when empty
//   count, full, empty occupancy status
module cmd_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and count define validity,
  // so clearing the array would cost reset fan-out for no behavioural gain.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
  // NOTE: non-blocking assignments in clocked logic so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: buffers ALU commands and issues them one at a time.
//   clk, clear_n                  clock shared with the ALU, async active-low reset
//   cmd_valid/cmd_ready           command handshake, payload cmd_op/cmd_a/cmd_b
//   alu_opcode/alu_in1/alu_in2    registered drive into the ALU (NOOP when idle)
//   alu_out                       ALU combinational next result
//   rsp_valid/rsp_ready           response handshake, payload rsp_data/rsp_op/rsp_err
//   count                         command FIFO occupancy
module alu_issue_queue
  import alu_defs::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   clear_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_op,
  input  logic [W-1:0]           cmd_a,
  input  logic [W-1:0]           cmd_b,
  output logic [3:0]             alu_opcode,
  output logic [W-1:0]           alu_in1,
  output logic [W-1:0]           alu_in2,
  input  logic [W-1:0]           alu_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [W-1:0]           rsp_data,
  output logic [3:0]             rsp_op,
  output logic                   rsp_err,
  output logic [$clog2(DEPTH):0] count
);

  localparam int FW = 4 + 2*W;

  state_t        state, state_d;
  logic [FW-1:0] head;
  logic [3:0]    head_op;
  logic [W-1:0]  head_a, head_b;
  logic          full, empty, pop;
  logic          head_div0, head_legal;

  cmd_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk       (clk),
    .rst_n     (clear_n),
    .push      (cmd_valid),
    .push_data ({cmd_op, cmd_a, cmd_b}),
    .pop       (pop),
    .pop_data  (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Ready is purely occupancy based; a same-cycle pop does not free a slot.
  assign cmd_ready  = !full;
  assign head_op    = head[FW-1 -: 4];
  assign head_a     = head[2*W-1 -: W];
  assign head_b     = head[W-1:0];
  assign head_div0  = (head_op == OP_DIV) && (head_b == '0);
  assign head_legal = is_alu_op(head_op) && !head_div0;
  assign rsp_valid  = (state == ST_RESP);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state <= ST_IDLE;
    else          state <= state_d;
  end

  // NOTE: defaults first so every path assigns every output; no latches.
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    case (state)
      ST_IDLE: pop = !empty;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          pop = !empty;
          if (empty) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A popped head either goes to the ALU or is answered directly as an error.
    if (pop) state_d = head_legal ? ST_EXEC : ST_RESP;
  end

  // ALU drive and response register. The ALU sees a real opcode only for the
  // single EXEC cycle; its result is captured at the end of that cycle.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      alu_opcode <= OP_NOOP;
      alu_in1    <= '0;
      alu_in2    <= '0;
      rsp_data   <= '0;
      rsp_op     <= OP_NOOP;
      rsp_err    <= 1'b0;
    end else begin
      if (pop && head_legal) begin
        alu_opcode <= head_op;
        alu_in1    <= head_a;
        alu_in2    <= head_b;
      end else begin
        alu_opcode <= OP_NOOP;
      end

      if (state == ST_EXEC) begin
        rsp_data <= alu_out;
        rsp_op   <= alu_opcode;
        rsp_err  <= 1'b0;
      end else if (pop && !head_legal) begin
        rsp_data <= head_div0 ? '1 : '0;
        rsp_op   <= head_op;
        rsp_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;
  import alu_defs::*;

  localparam int W     = 16;
  localparam int DEPTH = 4;

  logic          clk, clear_n;
  logic          cmd_valid, cmd_ready;
  logic [3:0]    cmd_op;
  logic [W-1:0]  cmd_a, cmd_b;
  logic [3:0]    alu_opcode;
  logic [W-1:0]  alu_in1, alu_in2, alu_out;
  logic          rsp_valid, rsp_ready;
  logic [W-1:0]  rsp_data;
  logic [3:0]    rsp_op;
  logic          rsp_err;
  logic [2:0]    count;

  alu_issue_queue #(.W(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_opcode (alu_opcode),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_out    (alu_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_op     (rsp_op),
    .rsp_err    (rsp_err),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: combinational next value, register holds on NOOP.
  logic [W-1:0] alu_q;
  always_comb begin
    alu_out = alu_q;
    case (alu_opcode)
      OP_ADD:   alu_out = alu_in1 + alu_in2;
      OP_SUB:   alu_out = alu_in1 - alu_in2;
      OP_MULT:  alu_out = alu_in1 * alu_in2;
      OP_DIV:   alu_out = (alu_in2 != '0) ? alu_in1 / alu_in2 : '1;
      OP_AND:   alu_out = alu_in1 & alu_in2;
      OP_OR:    alu_out = alu_in1 | alu_in2;
      OP_XOR:   alu_out = alu_in1 ^ alu_in2;
      OP_NOT:   alu_out = ~alu_in1;
      OP_RESET: alu_out = '0;
      default:  alu_out = alu_q;
    endcase
  end
  always @(posedge clk) alu_q <= alu_out;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response log: one record per rsp handshake edge.
  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] data;
    logic         err;
    int           cyc;
  } rsp_t;
  rsp_t got_q[$];
  int   cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clear_n && rsp_valid && rsp_ready)
      got_q.push_back('{rsp_op, rsp_data, rsp_err, cyc});
  end

  // Protocol monitors on the ALU drive.
  int div0_issued = 0;
  int bad_issue   = 0;
  int noop_viol   = 0;
  logic watch_noop = 1'b0;
  always @(negedge clk) begin
    if (alu_opcode == OP_DIV && alu_in2 == '0) div0_issued <= div0_issued + 1;
    if (alu_opcode > OP_NOT) bad_issue <= bad_issue + 1;
    if (watch_noop && alu_opcode != OP_NOOP) noop_viol <= noop_viol + 1;
  end

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic push(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int t = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      tests++; fails++;
      $display("FAIL push_timeout: cmd_ready stayed %b, required 1", cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsps(input string name, input int n);
    int t = 0;
    while (got_q.size() < n && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(name, got_q.size(), n);
  endtask

  task automatic check_rsp(input string name, input int i, input logic [3:0] op,
                           input logic [W-1:0] d, input logic e);
    if (i < got_q.size()) begin
      check({name, "_op"},   got_q[i].op,   op);
      check({name, "_data"}, got_q[i].data, d);
      check({name, "_err"},  got_q[i].err,  e);
    end else begin
      tests++; fails++;
      $display("FAIL %s: response %0d missing, got %0d responses", name, i, got_q.size());
    end
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] data;
    logic         err;
  } vec_t;
  vec_t vecs[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{OP_ADD,   16'h0001, 16'h0001, 16'h0002, 1'b0};
    vecs[1]  = '{OP_ADD,   16'hFFFF, 16'h0001, 16'h0000, 1'b0};
    vecs[2]  = '{OP_SUB,   16'h000F, 16'h0001, 16'h000E, 1'b0};
    vecs[3]  = '{OP_MULT,  16'h0002, 16'h0002, 16'h0004, 1'b0};
    vecs[4]  = '{OP_MULT,  16'h0100, 16'h0100, 16'h0000, 1'b0};
    vecs[5]  = '{OP_AND,   16'hFF00, 16'h7E00, 16'h7E00, 1'b0};
    vecs[6]  = '{OP_OR,    16'h00F0, 16'h0F00, 16'h0FF0, 1'b0};
    vecs[7]  = '{OP_XOR,   16'hFFFF, 16'h00FF, 16'hFF00, 1'b0};
    vecs[8]  = '{OP_NOT,   16'h1234, 16'h0000, 16'hEDCB, 1'b0};
    vecs[9]  = '{OP_DIV,   16'h0007, 16'h0002, 16'h0003, 1'b0};
    vecs[10] = '{OP_DIV,   16'h0007, 16'h0000, 16'hFFFF, 1'b1};
    vecs[11] = '{4'b1010,  16'h0005, 16'h0003, 16'h0000, 1'b1};
    vecs[12] = '{OP_RESET, 16'h0005, 16'h0003, 16'h0000, 1'b1};
    vecs[13] = '{OP_NOOP,  16'h0005, 16'h0003, 16'h0000, 1'b1};

    cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    clear_n = 1'b1;
    #1 clear_n = 1'b0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk);
    check("rst_count",      count,      0);
    check("rst_cmd_ready",  cmd_ready,  1);
    check("rst_rsp_valid",  rsp_valid,  0);
    check("rst_rsp_data",   rsp_data,   0);
    check("rst_rsp_op",     rsp_op,     0);
    check("rst_rsp_err",    rsp_err,    0);
    check("rst_alu_opcode", alu_opcode, 0);
    check("rst_alu_in1",    alu_in1,    0);
    check("rst_alu_in2",    alu_in2,    0);

    // ---- table: single command into an idle queue, latency checked ----
    rsp_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      push(vecs[i].op, vecs[i].a, vecs[i].b);              // now after edge k
      check($sformatf("v%0d_k_valid", i), rsp_valid, 0);
      @(negedge clk);                                      // after edge k+1
      if (vecs[i].err) begin
        check($sformatf("v%0d_valid", i),  rsp_valid,  1);
        check($sformatf("v%0d_data", i),   rsp_data,   vecs[i].data);
        check($sformatf("v%0d_op", i),     rsp_op,     vecs[i].op);
        check($sformatf("v%0d_err", i),    rsp_err,    1);
        check($sformatf("v%0d_aluop", i),  alu_opcode, OP_NOOP);
      end else begin
        check($sformatf("v%0d_issue_op", i), alu_opcode, vecs[i].op);
        check($sformatf("v%0d_k1_valid", i), rsp_valid,  0);
        @(negedge clk);                                    // after edge k+2
        check($sformatf("v%0d_valid", i),  rsp_valid,  1);
        check($sformatf("v%0d_data", i),   rsp_data,   vecs[i].data);
        check($sformatf("v%0d_op", i),     rsp_op,     vecs[i].op);
        check($sformatf("v%0d_err", i),    rsp_err,    0);
        check($sformatf("v%0d_aluop", i),  alu_opcode, OP_NOOP);
      end
    end
    @(negedge clk);
    check("table_drained_valid", rsp_valid, 0);

    // ---- back-to-back ALU ops: in order, 2 cycles apart ----
    got_q.delete();
    push(OP_SUB,  16'h000F, 16'h0001);
    push(OP_MULT, 16'h0002, 16'h0002);
    push(OP_AND,  16'hFF00, 16'h7E00);
    wait_rsps("b2b_count", 3);
    check_rsp("b2b0", 0, OP_SUB,  16'h000E, 1'b0);
    check_rsp("b2b1", 1, OP_MULT, 16'h0004, 1'b0);
    check_rsp("b2b2", 2, OP_AND,  16'h7E00, 1'b0);
    if (got_q.size() >= 3) begin
      check("b2b_gap01", got_q[1].cyc - got_q[0].cyc, 2);
      check("b2b_gap12", got_q[2].cyc - got_q[1].cyc, 2);
    end

    // ---- divide by zero followed by a legal divide ----
    got_q.delete();
    push(OP_DIV, 16'h0007, 16'h0000);
    push(OP_DIV, 16'h0007, 16'h0002);
    wait_rsps("div_count", 2);
    check_rsp("div0", 0, OP_DIV, 16'hFFFF, 1'b1);
    check_rsp("div1", 1, OP_DIV, 16'h0003, 1'b0);

    // ---- illegal opcodes: one response per cycle, ALU kept on NOOP ----
    @(negedge clk);
    got_q.delete();
    watch_noop = 1'b1;
    push(4'b1010,  16'h0001, 16'h0002);
    push(OP_RESET, 16'h0003, 16'h0004);
    wait_rsps("illegal_count", 2);
    @(negedge clk);
    watch_noop = 1'b0;
    check_rsp("ill0", 0, 4'b1010,  16'h0000, 1'b1);
    check_rsp("ill1", 1, OP_RESET, 16'h0000, 1'b1);
    if (got_q.size() >= 2) check("illegal_gap", got_q[1].cyc - got_q[0].cyc, 1);
    check("illegal_noop_held", noop_viol, 0);

    // ---- backpressure: FIFO fills, 6th command stalls, then drains ----
    got_q.delete();
    rsp_ready = 1'b0;
    push(OP_ADD,  16'h0001, 16'h0002);
    push(OP_SUB,  16'h000A, 16'h0003);
    push(OP_XOR,  16'hF0F0, 16'hFF00);
    push(OP_OR,   16'h0001, 16'h0002);
    push(OP_MULT, 16'h0003, 16'h0005);
    check("bp_count_full", count,     4);
    check("bp_ready_low",  cmd_ready, 0);
    check("bp_held_valid", rsp_valid, 1);
    check("bp_held_data",  rsp_data,  16'h0003);
    cmd_op = OP_NOT; cmd_a = 16'h0000; cmd_b = 16'h0000; cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("bp_stall_ready", cmd_ready,    0);
    check("bp_stall_count", count,        4);
    check("bp_stall_rsps",  got_q.size(), 0);
    check("bp_stall_data",  rsp_data,     16'h0003);
    rsp_ready = 1'b1;
    push(OP_NOT, 16'h0000, 16'h0000);
    wait_rsps("bp_count", 6);
    repeat (5) @(negedge clk);
    check("bp_no_dup", got_q.size(), 6);
    check_rsp("bp0", 0, OP_ADD,  16'h0003, 1'b0);
    check_rsp("bp1", 1, OP_SUB,  16'h0007, 1'b0);
    check_rsp("bp2", 2, OP_XOR,  16'h0FF0, 1'b0);
    check_rsp("bp3", 3, OP_OR,   16'h0003, 1'b0);
    check_rsp("bp4", 4, OP_MULT, 16'h000F, 1'b0);
    check_rsp("bp5", 5, OP_NOT,  16'hFFFF, 1'b0);

    // ---- clear_n during EXEC with 3 buffered ----
    rsp_ready = 1'b0;
    push(OP_ADD, 16'h0001, 16'h0001);
    push(OP_ADD, 16'h0002, 16'h0002);
    push(OP_ADD, 16'h0003, 16'h0003);
    push(OP_ADD, 16'h0004, 16'h0004);
    push(OP_ADD, 16'h0005, 16'h0005);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("clr_pre_aluop", alu_opcode, OP_ADD);
    check("clr_pre_in1",   alu_in1,    16'h0002);
    check("clr_pre_count", count,      3);
    check("clr_pre_valid", rsp_valid,  0);
    clear_n = 1'b0;
    #1;
    check("clr_count",      count,      0);
    check("clr_cmd_ready",  cmd_ready,  1);
    check("clr_rsp_valid",  rsp_valid,  0);
    check("clr_rsp_data",   rsp_data,   0);
    check("clr_rsp_op",     rsp_op,     0);
    check("clr_rsp_err",    rsp_err,    0);
    check("clr_alu_opcode", alu_opcode, 0);
    check("clr_alu_in1",    alu_in1,    0);
    check("clr_alu_in2",    alu_in2,    0);
    @(negedge clk);
    clear_n = 1'b1;
    got_q.delete();
    repeat (10) @(negedge clk);
    check("clr_no_rsp",      got_q.size(), 0);
    check("clr_after_count", count,        0);
    check("clr_after_valid", rsp_valid,    0);

    // ---- ALU drive never carried DIV by zero or a non-ALU opcode ----
    check("no_div0_issued", div0_issued, 0);
    check("no_bad_issue",   bad_issue,   0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
